// File: rtl/rv32_mc_ctrl_if.sv
// Memory handshakes, datapath hooks and status outputs of the RV32I multi-cycle sequencer.
// master = sequencer side, slave = memories/datapath/observer side.
interface rv32_mc_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;
  logic            cmp_true;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic            rf_we;
  logic            retire;
  logic [31:0]     retire_cnt;
  logic            halted;
  logic [1:0]      halt_cause;

  modport master (
    output imem_req, dmem_req, dmem_we, pc, ir, rf_we, retire, retire_cnt, halted, halt_cause,
    input  imem_ack, imem_rdata, dmem_ack, cmp_true, target
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we, pc, ir, rf_we, retire, retire_cnt, halted, halt_cause,
    output imem_ack, imem_rdata, dmem_ack, cmp_true, target
  );
endinterface

// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle RV32I control sequencer: owns PC/IR and steps each instruction through
// FETCH, DECODE, EXEC, MEM and WB, halting on env calls or illegal/misaligned control flow.
module rv32_mc_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  rv32_mc_ctrl_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] C_NONE    = 2'd0;
  localparam logic [1:0] C_EBREAK  = 2'd1;
  localparam logic [1:0] C_ECALL   = 2'd2;
  localparam logic [1:0] C_ILLEGAL = 2'd3;

  logic [2:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [31:0]     r_retire_cnt;
  logic [1:0]      r_cause;
  logic            r_take;
  logic [XLEN-1:0] r_tgt;

  // Opcode group decode straight off the IR, which is stable from DECODE through WB.
  logic [6:0] w_op;
  logic w_is_ralu, w_is_ialu, w_is_load, w_is_store, w_is_branch;
  logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_is_env;
  logic w_legal, w_ecall, w_ebreak, w_rd_nz, w_writes_rd, w_wb_fault, w_wb_ok;

  assign w_op        = r_ir[6:0];
  assign w_is_ralu   = (w_op == 7'b0110011);
  assign w_is_ialu   = (w_op == 7'b0010011);
  assign w_is_load   = (w_op == 7'b0000011);
  assign w_is_store  = (w_op == 7'b0100011);
  assign w_is_branch = (w_op == 7'b1100011);
  assign w_is_jal    = (w_op == 7'b1101111);
  assign w_is_jalr   = (w_op == 7'b1100111);
  assign w_is_lui    = (w_op == 7'b0110111);
  assign w_is_auipc  = (w_op == 7'b0010111);
  assign w_is_env    = (w_op == 7'b1110011);

  assign w_legal = w_is_ralu | w_is_ialu | w_is_load | w_is_store | w_is_branch |
                   w_is_jal | w_is_jalr | w_is_lui | w_is_auipc | w_is_env;
  assign w_ecall  = (r_ir[31:7] == 25'd0);
  assign w_ebreak = (r_ir[31:20] == 12'd1) && (r_ir[19:7] == 13'd0);

  assign w_rd_nz     = (r_ir[11:7] != 5'd0);
  assign w_writes_rd = w_is_ralu | w_is_ialu | w_is_load | w_is_jal | w_is_jalr |
                       w_is_lui | w_is_auipc;

  // A taken jump/branch to a non-word-aligned target faults in WB instead of retiring.
  assign w_wb_fault = r_take && (r_tgt[1:0] != 2'b00);
  assign w_wb_ok    = !rst && (r_state == S_WB) && !w_wb_fault;

  assign bus.imem_req   = !rst && (r_state == S_FETCH);
  assign bus.dmem_req   = !rst && (r_state == S_MEM);
  assign bus.dmem_we    = !rst && (r_state == S_MEM) && w_is_store;
  assign bus.retire     = w_wb_ok;
  assign bus.rf_we      = w_wb_ok && w_writes_rd && w_rd_nz;
  assign bus.pc         = r_pc;
  assign bus.ir         = r_ir;
  assign bus.retire_cnt = r_retire_cnt;
  assign bus.halted     = (r_state == S_HALT);
  assign bus.halt_cause = r_cause;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_ir         <= 32'd0;
      r_retire_cnt <= 32'd0;
      r_cause      <= C_NONE;
      r_take       <= 1'b0;
      r_tgt        <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_ir    <= bus.imem_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!w_legal || (r_ir[1:0] != 2'b11)) begin
            r_cause <= C_ILLEGAL;
            r_state <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_take <= w_is_jal | w_is_jalr | (w_is_branch & bus.cmp_true);
          r_tgt  <= w_is_jalr ? {bus.target[XLEN-1:1], 1'b0} : bus.target;
          if (w_is_env) begin
            r_state <= S_HALT;
            r_cause <= w_ecall ? C_ECALL : (w_ebreak ? C_EBREAK : C_ILLEGAL);
          end else if (w_is_load || w_is_store) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            r_state <= S_WB;
          end
        end
        S_WB: begin
          if (w_wb_fault) begin
            r_cause <= C_ILLEGAL;
            r_state <= S_HALT;
          end else begin
            r_pc         <= r_take ? r_tgt : r_pc + 32'd4;
            r_retire_cnt <= r_retire_cnt + 32'd1;
            r_state      <= S_FETCH;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Directed bench for rv32_mc_ctrl: walks instructions through every state and halt cause,
// checking strobes, PC, IR and retire count against hand-computed values.
module tb_rv32_mc_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rv32_mc_ctrl_if #(.XLEN(32)) bus ();

  rv32_mc_ctrl #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a 1-cycle fetch ack; returns one step into DECODE.
  task automatic fetch(input logic [31:0] instr);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = instr;
    #1;
    chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
    cyc;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    #1;
    chk("decode_ir", bus.ir, instr);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    #1;
  endtask

  // Checks that a halted core keeps every strobe low for a few cycles, even with acks offered.
  task automatic quiet(input logic [1:0] cause);
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc;
      chk("halt_strobes", {27'd0, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.retire}, 32'd0);
      chk("halt_cause_held", {29'd0, bus.halted, bus.halt_cause}, {29'd0, 1'b1, cause});
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.dmem_ack   = 1'b0;
    bus.cmp_true   = 1'b0;
    bus.target     = 32'd0;

    // Reset cycle: strobes low, architectural state at reset values.
    cyc; cyc;
    chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_pc", bus.pc, 32'h8000_0000);
    chk("rst_ir", bus.ir, 32'd0);
    chk("rst_cnt", bus.retire_cnt, 32'd0);
    chk("rst_halt", {29'd0, bus.halted, bus.halt_cause}, 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,5: fetch ack in cycle 1, rf_we in cycle 4.
    fetch(32'h0050_0093);
    chk("addi_decode_req", {31'd0, bus.imem_req}, 32'd0);
    cyc;
    chk("addi_exec_rfwe", {31'd0, bus.rf_we}, 32'd0);
    cyc;
    chk("addi_wb_rfwe", {31'd0, bus.rf_we}, 32'd1);
    chk("addi_wb_retire", {31'd0, bus.retire}, 32'd1);
    chk("addi_wb_pc", bus.pc, 32'h8000_0000);
    cyc;
    chk("addi_pc", bus.pc, 32'h8000_0004);
    chk("addi_cnt", bus.retire_cnt, 32'd1);
    chk("addi_retire_off", {31'd0, bus.retire}, 32'd0);
    $display("txn ADDI  pc=%08h cnt=%0d", bus.pc, bus.retire_cnt);

    // SW with dmem_ack 3 cycles late: request held 4 cycles.
    fetch(32'h0011_2023);
    cyc;
    cyc;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.dmem_ack = 1'b1;
      #1;
      chk("sw_mem_req_we", {30'd0, bus.dmem_req, bus.dmem_we}, 32'd3);
      chk("sw_mem_rfwe", {31'd0, bus.rf_we}, 32'd0);
      cyc;
    end
    bus.dmem_ack = 1'b0;
    #1;
    chk("sw_wb_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("sw_wb_strobes", {30'd0, bus.rf_we, bus.retire}, 32'd1);
    cyc;
    chk("sw_pc", bus.pc, 32'h8000_0008);
    chk("sw_cnt", bus.retire_cnt, 32'd2);
    $display("txn SW    pc=%08h cnt=%0d", bus.pc, bus.retire_cnt);

    // BEQ taken.
    fetch(32'h0000_0063);
    cyc;
    bus.cmp_true = 1'b1;
    bus.target   = 32'h8000_0100;
    cyc;
    bus.cmp_true = 1'b0;
    chk("beqt_wb_strobes", {30'd0, bus.rf_we, bus.retire}, 32'd1);
    cyc;
    chk("beqt_pc", bus.pc, 32'h8000_0100);
    chk("beqt_cnt", bus.retire_cnt, 32'd3);
    $display("txn BEQ-T pc=%08h cnt=%0d", bus.pc, bus.retire_cnt);

    // BEQ not taken.
    fetch(32'h0000_0063);
    cyc;
    bus.cmp_true = 1'b0;
    bus.target   = 32'h8000_0000;
    cyc;
    chk("beqn_wb_strobes", {30'd0, bus.rf_we, bus.retire}, 32'd1);
    cyc;
    chk("beqn_pc", bus.pc, 32'h8000_0104);
    $display("txn BEQ-N pc=%08h cnt=%0d", bus.pc, bus.retire_cnt);

    // JAL x0 to an aligned target: no register write.
    fetch(32'h0000_006F);
    cyc;
    bus.target = 32'h8000_0200;
    cyc;
    chk("jal_wb_strobes", {30'd0, bus.rf_we, bus.retire}, 32'd1);
    cyc;
    chk("jal_pc", bus.pc, 32'h8000_0200);
    chk("jal_cnt", bus.retire_cnt, 32'd5);
    $display("txn JAL   pc=%08h cnt=%0d", bus.pc, bus.retire_cnt);

    // LUI x5: writes rd, pc+4.
    fetch(32'h1234_52B7);
    cyc;
    cyc;
    chk("lui_wb_strobes", {30'd0, bus.rf_we, bus.retire}, 32'd3);
    cyc;
    chk("lui_pc", bus.pc, 32'h8000_0204);
    chk("lui_cnt", bus.retire_cnt, 32'd6);
    $display("txn LUI   pc=%08h cnt=%0d", bus.pc, bus.retire_cnt);

    // JALR to 0x80000203 -> bit0 cleared -> 0x80000202 misaligned -> halt cause 3.
    fetch(32'h0000_8067);
    cyc;
    bus.target = 32'h8000_0203;
    cyc;
    chk("jalr_wb_strobes", {30'd0, bus.rf_we, bus.retire}, 32'd0);
    cyc;
    chk("jalr_halt", {29'd0, bus.halted, bus.halt_cause}, {29'd0, 1'b1, 2'd3});
    chk("jalr_pc", bus.pc, 32'h8000_0204);
    chk("jalr_cnt", bus.retire_cnt, 32'd6);
    quiet(2'd3);
    $display("txn JALR  halted cause=%0d", bus.halt_cause);

    // ebreak -> cause 1; reset first clears the halt.
    do_reset;
    chk("rst_clears_halt", {29'd0, bus.halted, bus.halt_cause}, 32'd0);
    chk("rst_pc_after_halt", bus.pc, 32'h8000_0000);
    fetch(32'h0010_0073);
    cyc;
    chk("ebreak_exec_halted", {31'd0, bus.halted}, 32'd0);
    cyc;
    chk("ebreak_halt", {29'd0, bus.halted, bus.halt_cause}, {29'd0, 1'b1, 2'd1});
    chk("ebreak_cnt", bus.retire_cnt, 32'd0);
    quiet(2'd1);
    $display("txn EBRK  halted cause=%0d", bus.halt_cause);

    // ecall -> cause 2.
    do_reset;
    fetch(32'h0000_0073);
    cyc;
    cyc;
    chk("ecall_halt", {29'd0, bus.halted, bus.halt_cause}, {29'd0, 1'b1, 2'd2});
    quiet(2'd2);
    $display("txn ECALL halted cause=%0d", bus.halt_cause);

    // Unknown opcode 0x7F -> halts straight out of DECODE.
    do_reset;
    fetch(32'h0000_007F);
    cyc;
    chk("illop_halt", {29'd0, bus.halted, bus.halt_cause}, {29'd0, 1'b1, 2'd3});
    quiet(2'd3);
    $display("txn ILLOP halted cause=%0d", bus.halt_cause);

    // Compressed-style encoding (ir[1:0]=00) -> cause 3.
    do_reset;
    fetch(32'h0000_0010);
    cyc;
    chk("ilen_halt", {29'd0, bus.halted, bus.halt_cause}, {29'd0, 1'b1, 2'd3});
    $display("txn ILEN  halted cause=%0d", bus.halt_cause);

    // Non-standard ENV encoding -> cause 3.
    do_reset;
    fetch(32'h0020_0073);
    cyc;
    cyc;
    chk("envbad_halt", {29'd0, bus.halted, bus.halt_cause}, {29'd0, 1'b1, 2'd3});
    $display("txn ENV?  halted cause=%0d", bus.halt_cause);

    // Reset while a load waits in MEM.
    do_reset;
    fetch(32'h0000_A083);
    cyc;
    cyc;
    chk("lw_mem_req_we", {30'd0, bus.dmem_req, bus.dmem_we}, 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_mem_req", {31'd0, bus.dmem_req}, 32'd0);
    cyc;
    rst = 1'b0;
    #1;
    chk("post_rst_reqs", {30'd0, bus.imem_req, bus.dmem_req}, 32'd2);
    chk("post_rst_pc", bus.pc, 32'h8000_0000);
    chk("post_rst_cnt", bus.retire_cnt, 32'd0);

    // LW x1 with immediate dmem ack: 5-cycle instruction, writes rd.
    fetch(32'h0000_A083);
    cyc;
    cyc;
    bus.dmem_ack = 1'b1;
    #1;
    chk("lw_mem_req", {31'd0, bus.dmem_req}, 32'd1);
    cyc;
    bus.dmem_ack = 1'b0;
    #1;
    chk("lw_wb_strobes", {30'd0, bus.rf_we, bus.retire}, 32'd3);
    cyc;
    chk("lw_pc", bus.pc, 32'h8000_0004);
    chk("lw_cnt", bus.retire_cnt, 32'd1);
    $display("txn LW    pc=%08h cnt=%0d", bus.pc, bus.retire_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
